// File: rtl/present_dec_la.sv
// rtl/present_dec_la.sv - PRESENT-80 iterative decryption engine on the Caravel logic-analyzer port
module present_dec_la (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   inout  wire         vdd,
   inout  wire         vss,
   input  logic [38:0] la_data_in,
   output logic [31:0] la_data_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEYEXP,
      S_WHITEN,
      S_ROUND,
      S_DONE
   } state_t;

   localparam logic [31:0] ID_WORD = 32'h5052_4431;

   state_t        state;
   logic [38:0]   in_q;
   logic [38:0]   in_qq;
   logic [63:0]   ct;
   logic [79:0]   key;
   logic [63:0]   x;
   logic [79:0]   k;
   logic [63:0]   pt;
   logic [4:0]    c;
   logic          done;

   logic          wr_edge;
   logic          st_edge;
   logic          busy;
   logic [79:0]   k_fwd;
   logic [79:0]   k_inv;
   logic [63:0]   x_perm;
   logic [63:0]   x_sub;

   wire unused_pwr = vdd ^ vss;

   function automatic logic [3:0] sbox(input logic [3:0] v);
      case (v)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
      endcase
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] v);
      case (v)
         4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
         4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
         4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
         4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
      endcase
   endfunction

   function automatic logic [79:0] key_fwd(input logic [79:0] kin, input logic [4:0] rc);
      logic [79:0] t;
      t          = {kin[18:0], kin[79:19]};
      t[79:76]   = sbox(t[79:76]);
      t[19:15]   = t[19:15] ^ rc;
      return t;
   endfunction

   // Exact inverse of key_fwd: undo the counter xor, the S-box, then the rotation.
   function automatic logic [79:0] key_inv(input logic [79:0] kin, input logic [4:0] rc);
      logic [79:0] t;
      t          = kin;
      t[19:15]   = t[19:15] ^ rc;
      t[79:76]   = sbox_inv(t[79:76]);
      return {t[60:0], t[79:61]};
   endfunction

   for (genvar i = 0; i < 63; i++) begin : g_pinv
      assign x_perm[i] = x[(16 * i) % 63];
   end
   assign x_perm[63] = x[63];

   for (genvar n = 0; n < 16; n++) begin : g_sinv
      assign x_sub[4*n +: 4] = sbox_inv(x_perm[4*n +: 4]);
   end

   always_comb begin
      wr_edge = in_q[35] & ~in_qq[35];
      st_edge = in_q[36] & ~in_qq[36];
      busy    = (state == S_KEYEXP) || (state == S_WHITEN) || (state == S_ROUND);
      k_fwd   = key_fwd(k, c);
      k_inv   = key_inv(k, c);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         in_q        <= '0;
         in_qq       <= '0;
         ct          <= '0;
         key         <= '0;
         x           <= '0;
         k           <= '0;
         pt          <= '0;
         c           <= '0;
         done        <= 1'b0;
         state       <= S_IDLE;
         la_data_out <= '0;
      end else begin
         in_q  <= la_data_in;
         in_qq <= in_q;

         case (in_q[38:37])
            2'd0:    la_data_out <= pt[31:0];
            2'd1:    la_data_out <= pt[63:32];
            2'd2:    la_data_out <= {30'b0, done, busy};
            default: la_data_out <= ID_WORD;
         endcase

         case (state)
            S_IDLE: begin
               // A write edge in the same cycle takes precedence over start.
               if (st_edge && !wr_edge) begin
                  done  <= 1'b0;
                  x     <= ct;
                  k     <= key;
                  c     <= 5'd1;
                  state <= S_KEYEXP;
               end
            end
            S_KEYEXP: begin
               k <= k_fwd;
               if (c == 5'd31) begin
                  state <= S_WHITEN;
               end else begin
                  c <= c + 5'd1;
               end
            end
            S_WHITEN: begin
               x     <= x ^ k[79:16];
               c     <= 5'd31;
               state <= S_ROUND;
            end
            S_ROUND: begin
               x <= x_sub ^ k_inv[79:16];
               k <= k_inv;
               if (c == 5'd1) begin
                  state <= S_DONE;
               end else begin
                  c <= c - 5'd1;
               end
            end
            S_DONE: begin
               pt    <= x;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (wr_edge && !busy) begin
            case (in_q[34:32])
               3'd0: begin ct[31:0]   <= in_q[31:0];  done <= 1'b0; end
               3'd1: begin ct[63:32]  <= in_q[31:0];  done <= 1'b0; end
               3'd2: begin key[31:0]  <= in_q[31:0];  done <= 1'b0; end
               3'd3: begin key[63:32] <= in_q[31:0];  done <= 1'b0; end
               3'd4: begin key[79:64] <= in_q[15:0];  done <= 1'b0; end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/present_dec_la.md
# present_dec_la

PRESENT-80 decryption engine driven over the Caravel logic-analyzer port: the inverse-direction companion of the PRESENT encryption core in the user project area. Software loads a 64-bit ciphertext and 80-bit key as 32-bit words through `la_data_in`, pulses start, and reads the 64-bit plaintext and status back through `la_data_out`. Iterative core: one round per clock, on-chip forward key expansion followed by the inverse key schedule.

## Interface
- No parameters. Key size is fixed at 80 bits, block size at 64 bits, and the round count at 31.
- `wb_clk_i`  in  1  clock. All logic is on the rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `vdd`, `vss`  inout  1  power pins, present for the gate-level netlist only.
- `la_data_in`  in  39  LA control word:
  - [31:0] write data.
  - [34:32] write word select.
  - [35] write strobe, rising edge.
  - [36] start, rising edge.
  - [38:37] read select.
- `la_data_out`  out  32  registered read data.

## Operation
- **Input stage:** `la_data_in` is registered into `in_q` every cycle, then copied to `in_qq`. A strobe edge is `in_q[b] & ~in_qq[b]`. All decode uses `in_q`.
- **Write map** (applied on a bit-35 edge, only while not busy):
  - 0: ct[31:0]
  - 1: ct[63:32]
  - 2: key[31:0]
  - 3: key[63:32]
  - 4: key[79:64] ← data[15:0]
  - 5–7: ignored, no state change.
  - Any accepted write clears `done`.
- **Read map** (`in_q[38:37]`):
  - 0: pt[31:0]
  - 1: pt[63:32]
  - 2: {30'b0, done, busy}
  - 3: 32'h5052_4431, the ID word.
- **Start:** a bit-36 edge while IDLE clears `done`, copies ct and key into working registers `x` and `k`, and moves to KEYEXP.
  - Start while busy is ignored.
  - Start and write edges in the same cycle: the write is performed and the start is ignored.
- **Forward key update (round counter c):**
  - Rotate k left by 61.
  - k[79:76] = S(k[79:76]).
  - k[19:15] ^= c.
- **Inverse key update (round counter c):**
  - k[19:15] ^= c.
  - k[79:76] = S⁻¹(k[79:76]).
  - Rotate k right by 61.
- **State machine:**
  - IDLE: waits for start.
  - KEYEXP: c runs 1..31, one forward update per cycle, 31 cycles. It ends with k = K32.
  - WHITEN: x = x ^ k[79:16], 1 cycle. Sets c = 31.
  - ROUND: 31 cycles, c runs 31 down to 1. Each cycle:
    - knext = invupdate(k, c), which equals K_c.
    - x = S⁻¹-layer(P⁻¹(x)) ^ knext[79:16].
    - k = knext.
  - DONE: 1 cycle. pt ← x, `done` ← 1, then back to IDLE.
- **Permutation layers:**
  - P⁻¹ maps destination bit i to source bit P(i), where P(i) = 16·i mod 63 for i < 63 and P(63) = 63. Equivalently, bit P(i) of the input goes to bit i of the output.
  - The S⁻¹-layer applies the 4-bit inverse box to all 16 nibbles.
  - S = C56B90AD3EF84712 (hex, index 0..F). S⁻¹ = 5EF8C12DB463079A.
- **Register locking:** ct and key holding registers are unchanged by decryption. They are writable only while not busy.
- **busy** is high in KEYEXP, WHITEN and ROUND.

## Timing
- **Reset:**
  - All registers are 0: in_q, in_qq, ct, key, x, k, pt, c, `done`, and the state (IDLE).
  - `la_data_out` = 0 on the cycle after the reset edge.
  - Reset mid-operation aborts immediately. No pt update, `done` = 0.
- **Edge latency:** a bit first sampled high at edge n is in `in_q` after edge n and acted on at edge n+1. A held-high bit produces exactly one edge.
- **Start-to-done latency:**
  - The start edge is acted on at edge t. Busy is visible in state from t.
  - KEYEXP runs t..t+30, WHITEN t+31, ROUND t+32..t+62, DONE t+63.
  - pt and `done` are valid after edge t+64. Busy is high for exactly 63 cycles.
- **Read latency:** `la_data_out` updates at the edge after `in_q` changes. Total LA-in to LA-out latency is 2 cycles.
- **Status coherence:** `done` and pt update on the same edge, so there is no cycle in which `done` = 1 with a stale pt.
- **Back-to-back starts:** the next start is accepted from the cycle after DONE.

## Test plan
- Reset, then read select 3 → `la_data_out` = 32'h5052_4431. Read select 0/1/2 → 0.
- key = 0, ct = 5579C1387B228445, start → after 64 cycles status = 2, pt = 0000000000000000. Busy must be seen high for exactly 63 sampled cycles.
- key = FFFFFFFFFFFFFFFFFFFF, ct = E72C46C0F5945049 → pt = 0. Then ct = 3333DCD3213210D2 → pt = FFFFFFFFFFFFFFFF. Cover back-to-back starts with no key reload.
- key = 0, ct = A112FFC72F68417B → pt = FFFFFFFFFFFFFFFF. Mid-run, pulse a write to word 0 and a second start: both ignored, result unchanged.
- Assert reset at busy cycle 40 → status = 0 and pt = 0 next read. A rerun with reloaded words gives correct pt.
- Write and start edges in the same cycle → write lands (read back via a decrypt of the new ct), no busy. A write to select 6 changes nothing.
